// File: rtl/inst_fetcher_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetcher_pkg
//   Shared constants and types for the instruction fetch stage:
//   instruction/address widths, the "empty" PC marker shown to the decoder,
//   TRUE/FALSE, load/store opcodes, the fetch FSM state encoding, and the
//   {pc, inst} entry stored in the instruction FIFO.
// -----------------------------------------------------------------------------
package inst_fetcher_pkg;

   localparam int INST_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;

   // PC value presented to the decoder when no instruction is available.
   localparam logic [ADDR_WIDTH-1:0] EMPTY_INST = 32'hFFFF_FFFF;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_WAIT = 2'd1,
      IF_DROP = 2'd2
   } if_state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [INST_WIDTH-1:0] inst;
   } fifo_entry_t;

   function automatic logic is_load_store(input logic [INST_WIDTH-1:0] inst);
      return (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);
   endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// -----------------------------------------------------------------------------
// inst_fetcher_if
//   Bundles the fetcher's decoder-side and memory-side signals.
//   master : the fetcher (drives decoder outputs and the fetch request)
//   slave  : the environment (decoder/ROB and memory controller)
//   Decoder side : if_station_idle, inst_to_dec, pc_to_dec, if_ls_to_dec
//   Memory side  : if_fetch_req, fetch_addr, inst_valid_from_mem, inst_from_mem
//   ROB redirect : if_jump, jump_pc
// -----------------------------------------------------------------------------
interface inst_fetcher_if;

   logic        if_station_idle;
   logic [31:0] inst_to_dec;
   logic [31:0] pc_to_dec;
   logic        if_ls_to_dec;
   logic        if_fetch_req;
   logic [31:0] fetch_addr;
   logic        inst_valid_from_mem;
   logic [31:0] inst_from_mem;
   logic        if_jump;
   logic [31:0] jump_pc;

   modport master (
      input  if_station_idle, inst_valid_from_mem, inst_from_mem, if_jump, jump_pc,
      output inst_to_dec, pc_to_dec, if_ls_to_dec, if_fetch_req, fetch_addr
   );

   modport slave (
      output if_station_idle, inst_valid_from_mem, inst_from_mem, if_jump, jump_pc,
      input  inst_to_dec, pc_to_dec, if_ls_to_dec, if_fetch_req, fetch_addr
   );

endinterface

// File: rtl/inst_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
//   Circular buffer of {pc, inst} entries for the fetch stage.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     i_push/i_din: write an entry at the tail
//     i_pop       : retire the head entry
//     i_clear     : empty the buffer (wins over push/pop)
//     o_head      : entry at the head (valid only when o_count != 0)
//     o_count     : occupied entries, 0..DEPTH
//     o_full      : o_count == DEPTH
//   DEPTH must be a power of two >= 2 so the pointers wrap for free.
// -----------------------------------------------------------------------------
module inst_fifo
   import inst_fetcher_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  fifo_entry_t              i_din,
   input  logic                     i_pop,
   input  logic                     i_clear,
   output fifo_entry_t              o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   fifo_entry_t   r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [PW:0]   r_count;

   logic w_do_push;
   logic w_do_pop;

   // A push into a full buffer is only legal when the head leaves the same cycle.
   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

   // NOTE: the storage array has no reset; an entry is only ever read after it
   // was written, and leaving it out of reset keeps it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_clear) begin
         r_mem[r_tail] <= i_din;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_tail <= r_tail + 1'b1;
         if (w_do_pop)  r_head <= r_head + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/inst_fetcher.sv
// -----------------------------------------------------------------------------
// inst_fetcher
//   Fetch stage: requests 32-bit instructions at a sequential PC, buffers
//   them in inst_fifo and presents the head to the decoder.
//   Ports:
//     clk_in  : clock
//     rst_in  : asynchronous active-low reset
//     rdy_in  : global ready; all state holds while low
//     bus     : inst_fetcher_if.master (decoder, memory and redirect signals)
//   Parameters: QUEUE_DEPTH (power of two >= 2), RESET_PC.
//   Optional: define IFETCH_BYPASS_EN to forward a response straight to the
//   decoder when the FIFO is empty (zero-cycle fetch-to-issue).
// -----------------------------------------------------------------------------
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int          QUEUE_DEPTH = 8,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic           clk_in,
   input  logic           rst_in,
   input  logic           rdy_in,
   inst_fetcher_if.master bus
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   if_state_t   r_state;
   logic [31:0] r_pc;
   logic        r_fetch_req;
   logic [31:0] r_fetch_addr;

   fifo_entry_t w_head;
   fifo_entry_t w_din;
   logic [CW-1:0] w_count;
   logic        w_full;
   logic        w_empty;
   logic        w_resp;
   logic        w_push;
   logic        w_pop;
   logic        w_clear;
   logic [31:0] w_dec_inst;
   logic [31:0] w_dec_pc;
   logic        w_dec_ls;

   assign w_empty = (w_count == '0);
   // Only a response to our own outstanding request is meaningful.
   assign w_resp  = (r_state == IF_WAIT) && bus.inst_valid_from_mem;
   assign w_clear = rdy_in && bus.if_jump;
   assign w_pop   = rdy_in && !bus.if_jump && !w_empty && bus.if_station_idle;
   assign w_din   = '{pc: r_pc, inst: bus.inst_from_mem};

`ifdef IFETCH_BYPASS_EN
   logic w_bypass;
   logic w_bypass_take;
   assign w_bypass      = w_empty && w_resp && !bus.if_jump;
   assign w_bypass_take = w_bypass && rdy_in && bus.if_station_idle;
   assign w_push        = rdy_in && !bus.if_jump && w_resp && !w_bypass_take;
`else
   assign w_push        = rdy_in && !bus.if_jump && w_resp;
`endif

   inst_fifo #(
      .DEPTH   (QUEUE_DEPTH)
   ) u_fifo (
      .clk     (clk_in),
      .rst_n   (rst_in),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .i_clear (w_clear),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full)
   );

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      w_dec_inst = '0;
      w_dec_pc   = EMPTY_INST;
      w_dec_ls   = FALSE;
      if (!w_empty) begin
         w_dec_inst = w_head.inst;
         w_dec_pc   = w_head.pc;
         w_dec_ls   = is_load_store(w_head.inst);
      end
`ifdef IFETCH_BYPASS_EN
      else if (w_bypass) begin
         w_dec_inst = bus.inst_from_mem;
         w_dec_pc   = r_pc;
         w_dec_ls   = is_load_store(bus.inst_from_mem);
      end
`endif
   end

   // Fetch FSM. A request is only issued while the FIFO has room, and only one
   // request is ever outstanding, so the matching push can never overflow.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state      <= IF_IDLE;
         r_pc         <= RESET_PC;
         r_fetch_req  <= FALSE;
         r_fetch_addr <= RESET_PC;
      end else if (rdy_in) begin
         if (bus.if_jump) begin
            r_pc        <= bus.jump_pc;
            r_fetch_req <= FALSE;
            // A request still in flight must have its response swallowed.
            if ((r_state != IF_IDLE) && !bus.inst_valid_from_mem) begin
               r_state <= IF_DROP;
            end else begin
               r_state <= IF_IDLE;
            end
         end else begin
            unique case (r_state)
               IF_IDLE: begin
                  if (!w_full) begin
                     r_fetch_req  <= TRUE;
                     r_fetch_addr <= r_pc;
                     r_state      <= IF_WAIT;
                  end
               end
               IF_WAIT: begin
                  if (bus.inst_valid_from_mem) begin
                     r_fetch_req <= FALSE;
                     r_pc        <= r_pc + 32'd4;
                     r_state     <= IF_IDLE;
                  end
               end
               IF_DROP: begin
                  if (bus.inst_valid_from_mem) begin
                     r_state <= IF_IDLE;
                  end
               end
               default: r_state <= IF_IDLE;
            endcase
         end
      end
   end

   assign bus.if_fetch_req = r_fetch_req;
   assign bus.fetch_addr   = r_fetch_addr;
   assign bus.inst_to_dec  = w_dec_inst;
   assign bus.pc_to_dec    = w_dec_pc;
   assign bus.if_ls_to_dec = w_dec_ls;

endmodule

// File: tb/tb_inst_fetcher.sv
// -----------------------------------------------------------------------------
// tb_inst_fetcher
//   Directed bench for inst_fetcher (default build). Responses the fetcher
//   should keep are queued as expected {pc, inst} entries and compared
//   against the decoder outputs when each one is issued.
// -----------------------------------------------------------------------------
module tb_inst_fetcher;
   import inst_fetcher_pkg::*;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;

   inst_fetcher_if bus ();

   inst_fetcher #(
      .QUEUE_DEPTH (8),
      .RESET_PC    (32'h0)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;
   fifo_entry_t sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (bus.if_fetch_req !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("req_seen", {31'b0, bus.if_fetch_req}, 32'd1);
   endtask

   // Serve one request after lat cycles; queue it as expected if it should be kept.
   task automatic mem_respond(input logic [31:0] addr, input int lat,
                              input logic [31:0] data, input bit keep);
      wait_req();
      check("fetch_addr", bus.fetch_addr, addr);
      repeat (lat) step();
      check("req_held", {31'b0, bus.if_fetch_req}, 32'd1);
      check("addr_held", bus.fetch_addr, addr);
      bus.inst_valid_from_mem = 1'b1;
      bus.inst_from_mem       = data;
      if (keep) sb.push_back('{pc: addr, inst: data});
      step();
      bus.inst_valid_from_mem = 1'b0;
   endtask

   // Compare the head against the scoreboard, then let the decoder take it.
   task automatic issue_one();
      fifo_entry_t e;
      logic exp_ls;
      check("sb_has_entry", {31'b0, sb.size() > 0}, 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      exp_ls = (e.inst[6:0] == 7'h03) || (e.inst[6:0] == 7'h23);
      check("dec_pc", bus.pc_to_dec, e.pc);
      check("dec_inst", bus.inst_to_dec, e.inst);
      check("dec_ls", {31'b0, bus.if_ls_to_dec}, {31'b0, exp_ls});
      bus.if_station_idle = 1'b1;
      step();
      bus.if_station_idle = 1'b0;
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_pc"}, bus.pc_to_dec, EMPTY_INST);
      check({tag, "_inst"}, bus.inst_to_dec, 32'h0);
      check({tag, "_ls"}, {31'b0, bus.if_ls_to_dec}, 32'd0);
   endtask

   logic [31:0] fill_data [8] = '{32'h00012083, 32'h00112023, 32'h002081b3, 32'h00100093,
                                  32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};

   initial begin
      rst_in = 1'b0;
      rdy_in = 1'b1;
      bus.if_station_idle     = 1'b0;
      bus.inst_valid_from_mem = 1'b0;
      bus.inst_from_mem       = 32'h0;
      bus.if_jump             = 1'b0;
      bus.jump_pc             = 32'h0;
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_req", {31'b0, bus.if_fetch_req}, 32'd0);
      check("rst_addr", bus.fetch_addr, 32'h0);
      check_empty("rst");
      rst_in = 1'b1;
      step();

      // First fetch: 3-cycle memory, issued one cycle after the response.
      mem_respond(32'h0, 3, 32'h00000013, 1'b1);
      issue_one();
      check_empty("after_first");

      // Fill all 8 entries with a stalled decoder.
      for (int i = 0; i < 8; i++) begin
         mem_respond(32'h4 + 32'(4 * i), 1, fill_data[i], 1'b1);
      end
      repeat (3) step();
      check("full_no_req", {31'b0, bus.if_fetch_req}, 32'd0);
      issue_one();  // load at pc 4
      check("pop_edge_no_req", {31'b0, bus.if_fetch_req}, 32'd0);
      step();
      check("refill_req", {31'b0, bus.if_fetch_req}, 32'd1);
      check("refill_addr", bus.fetch_addr, 32'd36);
      issue_one();  // store
      issue_one();  // add
      issue_one();

      // Redirect while waiting for addr 36 with entries still queued.
      bus.if_jump = 1'b1;
      bus.jump_pc = 32'h100;
      bus.if_station_idle = 1'b1;
      step();
      bus.if_jump = 1'b0;
      bus.if_station_idle = 1'b0;
      sb.delete();
      check_empty("jump_flush");
      check("jump_req_drop", {31'b0, bus.if_fetch_req}, 32'd0);
      bus.inst_valid_from_mem = 1'b1;
      bus.inst_from_mem       = 32'hDEADBEEF;
      step();
      bus.inst_valid_from_mem = 1'b0;
      check_empty("late_resp");
      mem_respond(32'h100, 2, 32'h00a00113, 1'b1);
      issue_one();

      // Jump coincident with a response and an accepting decoder.
      mem_respond(32'h104, 1, 32'h00412183, 1'b1);
      wait_req();
      check("coinc_addr", bus.fetch_addr, 32'h108);
      bus.inst_valid_from_mem = 1'b1;
      bus.inst_from_mem       = 32'h00600313;
      bus.if_jump             = 1'b1;
      bus.jump_pc             = 32'h200;
      bus.if_station_idle     = 1'b1;
      step();
      bus.inst_valid_from_mem = 1'b0;
      bus.if_jump             = 1'b0;
      bus.if_station_idle     = 1'b0;
      sb.delete();
      check_empty("coinc");
      check("coinc_req", {31'b0, bus.if_fetch_req}, 32'd0);
      mem_respond(32'h200, 1, 32'h00312223, 1'b1);

      // rdy_in low: no pop and no new request.
      rdy_in = 1'b0;
      bus.if_station_idle = 1'b1;
      repeat (3) step();
      check("rdy_hold_pc", bus.pc_to_dec, 32'h200);
      check("rdy_hold_req", {31'b0, bus.if_fetch_req}, 32'd0);
      rdy_in = 1'b1;
      bus.if_station_idle = 1'b0;

      // Asynchronous reset in the middle of a wait.
      wait_req();
      check("pre_rst_addr", bus.fetch_addr, 32'h204);
      #2;
      rst_in = 1'b0;
      #1;
      check("arst_req", {31'b0, bus.if_fetch_req}, 32'd0);
      check("arst_addr", bus.fetch_addr, 32'h0);
      check_empty("arst");
      sb.delete();
      #3;
      rst_in = 1'b1;
      mem_respond(32'h0, 1, 32'h00002083, 1'b1);
      issue_one();
      check_empty("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Producer side of the fetch→decode interface. Fetches 32-bit instructions from the memory controller at a sequential PC and buffers them in a small FIFO.
- Presents the FIFO head to the decoder as inst/pc/is-load-store.
- Pops the head on the cycle the decoder reports the station idle.
- Redirects and flushes on a ROB jump/mispredict.

Parameters:
- QUEUE_DEPTH, 8, instruction FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, all state holds.
- if_station_idle  input  1  decoder/ROB/RS/LSB can accept the presented instruction this cycle.
- inst_to_dec  output  32  FIFO head instruction.
- pc_to_dec  output  32  FIFO head PC; `emptyInst when the FIFO is empty.
- if_ls_to_dec  output  1  head opcode is 7'b0000011 or 7'b0100011.
- if_fetch_req  output  1  request to memory controller.
- fetch_addr  output  32  request address.
- inst_valid_from_mem  input  1  one-cycle pulse; inst_from_mem is valid.
- inst_from_mem  input  32  fetched instruction.
- if_jump  input  1  ROB redirect.
- jump_pc  input  32  redirect target.

Behaviour:
- Reset (rst_in low, asynchronous):
  - pc ← RESET_PC.
  - FIFO empty: head = tail = count = 0.
  - state ← IDLE.
  - if_fetch_req = 0, fetch_addr = RESET_PC.
  - pc_to_dec = `emptyInst, inst_to_dec = 0, if_ls_to_dec = 0.
- Decoder outputs are combinational from the FIFO head. When count == 0: pc_to_dec = `emptyInst and if_ls_to_dec = 0.
- Pop happens when count > 0 && if_station_idle && rdy_in && !if_jump. The head advances at that edge, so exactly one instruction is issued per accepting cycle.
- FSM states IDLE, WAIT, DROP:
  - IDLE → WAIT when count + 0 < QUEUE_DEPTH, i.e. there is room including this request. On entry: if_fetch_req = 1, fetch_addr = pc.
  - WAIT: if_fetch_req and fetch_addr held stable until inst_valid_from_mem.
    - On the valid pulse: push {pc, inst}, pc ← pc + 4 (32-bit wrap), → IDLE.
    - If the FIFO became full meanwhile, the push is still guaranteed, because the request was only issued with room reserved and pops only free space.
  - DROP: waits for inst_valid_from_mem, discards the data, → IDLE. pc already holds the jump target.
- if_jump (takes priority over push, pop and request):
  - FIFO cleared (count ← 0) and pc ← jump_pc.
  - In WAIT: if_fetch_req deasserts next cycle and state → DROP. The in-flight response must never be enqueued.
  - In IDLE or DROP: state → IDLE or stays DROP, respectively.
  - A jump in the same cycle as inst_valid_from_mem: data discarded, state → IDLE.
- Simultaneous push and pop: count unchanged; head and tail both advance modulo QUEUE_DEPTH.
- Full (count == QUEUE_DEPTH): no new request issued; pop re-enables fetching the next cycle.
- Empty with pending fetch: decoder sees `emptyInst, and no pop occurs regardless of if_station_idle.
- rdy_in low: no push, pop, state or pc change. Request outputs hold.

Optional Feature:
- IFETCH_BYPASS_EN.
  - Defined: when the FIFO is empty and inst_valid_from_mem arrives, the new instruction/pc/if_ls are presented combinationally to the decoder in the same cycle. If if_station_idle is high, the instruction is consumed without a FIFO write (zero-cycle fetch-to-issue). if_jump still suppresses the bypass.
  - Undefined: every instruction is written to the FIFO first, giving a minimum one-cycle fetch-to-decode latency.

Decomposition:
- Shared package (defines.v): instWidth, addrWidth, emptyInst, TRUE/FALSE, opcode constants OP_LOAD = 7'b0000011 and OP_STORE = 7'b0100011, and the state encoding IF_IDLE/IF_WAIT/IF_DROP.
- One sub-module: inst_fifo (parameterised depth; 64-bit {pc, inst} entries; push/pop/clear; count/full/empty).

Test Plan:
- Reset then RESET_PC=0, memory returns 32'h00000013 after 3 cycles, if_station_idle=1 → fetch_addr=0; one cycle after valid, pc_to_dec=0, inst_to_dec=32'h13, if_ls_to_dec=0; next fetch_addr=4.
- if_station_idle held 0 with 1-cycle memory → exactly 8 pushes, if_fetch_req stays 0 when count=8; one idle cycle pops pc=0 and a request for 32 follows.
- Load 32'h00012083 at head → if_ls_to_dec=1; store 32'h00112023 → 1; add 32'h002081b3 → 0.
- Jump to 32'h100 while in WAIT for addr 12 → FIFO empty next cycle, pc_to_dec=`emptyInst; late response for 12 discarded; next fetch_addr=32'h100.
- if_jump coincident with inst_valid_from_mem and a pop → no push, no stale issue, count=0, fetch resumes at jump_pc.
- rst_in pulsed low mid-WAIT (asynchronous, between edges) → outputs immediately at reset values; fetch restarts at RESET_PC after release.
